// File: rtl/scr1_pipe_mul_ctrl.sv
// Issue/response controller for the 33x33 iterative multiplier (RV32M MUL/MULH/MULHSU/MULHU).
// Optional product/operand reuse cache enabled by defining SCR1_MUL_FUSE_EN.
module scr1_pipe_mul_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vd_i,
  output logic        req_rdy_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_op1_i,
  input  logic [31:0] req_op2_i,
  output logic        res_vd_o,
  output logic [31:0] res_o,
  input  logic        res_rdy_i,
  output logic        mul_valid_o,
  output logic [32:0] mul_din1_o,
  output logic [32:0] mul_din2_o,
  input  logic [31:0] mul_hig_i,
  input  logic [31:0] mul_low_i,
  input  logic        mul_rdy_i,
  output logic        mul_done_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned DW   = XLEN + 1;
  localparam int unsigned PW   = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      op_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [PW-1:0]   prod_q;
  logic            accept;
  logic            capture;
  logic            hit;

  // Bit[32] carries the sign: rs1 is signed for MULH/MULHSU, rs2 only for MULH
  function automatic logic [DW-1:0] form_din(input logic [1:0] op, input logic [XLEN-1:0] val,
                                             input logic first);
    logic sgn;
    sgn = (op == OP_MULH) || (first && (op == OP_MULHSU));
    return {sgn & val[XLEN-1], val};
  endfunction

  // Operands come from registers so they stay frozen through the correction cycle
  always_comb begin
    mul_din1_o = form_din(op_q, op1_q, 1'b1);
    mul_din2_o = form_din(op_q, op2_q, 1'b0);
    res_o      = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[PW-1:XLEN];
    mul_done_o = (state == ST_WAIT) && mul_rdy_i;
  end

`ifdef SCR1_MUL_FUSE_EN
  logic          cache_vld;
  logic [DW-1:0] cache_din1;
  logic [DW-1:0] cache_din2;
  logic [DW-1:0] new_din1;
  logic [DW-1:0] new_din2;

  // MUL only needs the magnitude bits to match: the low word ignores operand signs
  always_comb begin
    new_din1 = form_din(req_op_i, req_op1_i, 1'b1);
    new_din2 = form_din(req_op_i, req_op2_i, 1'b0);
    hit      = cache_vld &&
               (((new_din1 == cache_din1) && (new_din2 == cache_din2)) ||
                ((req_op_i == OP_MUL) &&
                 (new_din1[XLEN-1:0] == cache_din1[XLEN-1:0]) &&
                 (new_din2[XLEN-1:0] == cache_din2[XLEN-1:0])));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cache_vld  <= 1'b0;
      cache_din1 <= '0;
      cache_din2 <= '0;
    end else if (capture) begin
      cache_vld  <= 1'b1;
      cache_din1 <= mul_din1_o;
      cache_din2 <= mul_din2_o;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next-state and transaction strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_vd_i) begin
          accept     = 1'b1;
          state_next = hit ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (mul_rdy_i) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_rdy_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; handshake outputs are registered copies of the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      req_rdy_o   <= 1'b1;
      res_vd_o    <= 1'b0;
      mul_valid_o <= 1'b0;
      op_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      prod_q      <= '0;
    end else begin
      state       <= state_next;
      req_rdy_o   <= (state_next == ST_IDLE);
      res_vd_o    <= (state_next == ST_RESP);
      mul_valid_o <= (state_next == ST_ISSUE);
      if (accept) begin
        op_q  <= req_op_i;
        op1_q <= req_op1_i;
        op2_q <= req_op2_i;
      end
      if (capture) begin
        prod_q <= {mul_hig_i, mul_low_i};
      end
    end
  end

endmodule
